// File: rtl/apb_slave_regfile_if.sv
// apb_slave_regfile_if: APB bus between the bridge initiator and a register-file responder
interface apb_slave_regfile_if;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        Pready;
    logic        Pslverr;
    modport master (output Pselx, Penable, Pwrite, Paddr, Pwdata, input Prdata, Pready, Pslverr);
    modport slave (input Pselx, Penable, Pwrite, Paddr, Pwdata, output Prdata, Pready, Pslverr);
endinterface

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB responder with a 32-bit register file and optional access-phase wait states
module apb_slave_regfile #(
    parameter int unsigned SLV_ID      = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_STATES = 0
) (
    input logic                Hclk,
    input logic                Hreset,
    apb_slave_regfile_if.slave apb
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int WW = WAIT_STATES > 0 ? $clog2(WAIT_STATES + 1) : 1;
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;
    state_t        state, next;
    logic [31:0]   regs [DEPTH];
    logic [WW-1:0] wait_cnt;
    logic [AW-1:0] idx_q;
    logic [7:0]    idx;
    logic          wr_q, err_q, sel, err, latch, commit;
    assign sel = apb.Pselx[SLV_ID];
    assign idx = apb.Paddr[9:2];
    assign err = (apb.Paddr[31:10] != BASE_ADDR[31:10]) || (apb.Paddr[1:0] != 2'b00) || (32'(idx) >= DEPTH);
    assign apb.Pready = (state == S_ACCESS) && (wait_cnt == WW'(WAIT_STATES));
    assign apb.Pslverr = err_q && apb.Pready;
    assign latch = next == S_SETUP;
    assign commit = apb.Pready && sel && apb.Penable && wr_q && !err_q;
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) state <= S_IDLE;
        else state <= next;
    end
    always_comb begin
        next = S_IDLE;
        case (state)
            S_IDLE:   next = (sel && !apb.Penable) ? S_SETUP : S_IDLE;
            S_SETUP:  next = !sel ? S_IDLE : apb.Penable ? S_ACCESS : S_SETUP;
            S_ACCESS: next = (sel && apb.Penable && !apb.Pready) ? S_ACCESS : S_IDLE;
            default:  next = S_IDLE;
        endcase
    end
    // Every entry into S_SETUP (including a restart) relatches the request; reads fetch data here
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            wr_q <= 1'b0;
            err_q <= 1'b0;
            idx_q <= '0;
            wait_cnt <= '0;
            apb.Prdata <= 32'h0;
        end else if (latch) begin
            wr_q <= apb.Pwrite;
            err_q <= err;
            idx_q <= idx[AW-1:0];
            wait_cnt <= '0;
            if (!apb.Pwrite) apb.Prdata <= err ? 32'h0 : regs[idx[AW-1:0]];
        end else if (state == S_ACCESS && !apb.Pready) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= 32'h0;
        end else if (commit) begin
            regs[idx_q] <= apb.Pwdata;
        end
    end
endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: directed vector bench for zero-wait and two-wait-state register files
module tb_apb_slave_regfile;
    logic Hclk = 1'b0;
    logic Hreset = 1'b1;
    always #5 Hclk = ~Hclk;

    apb_slave_regfile_if ifa ();
    apb_slave_regfile_if ifb ();

    logic        tgt;
    logic [2:0]  psel;
    logic        pen, wr;
    logic [31:0] addr, wdata;
    logic [31:0] rd_m;
    logic        rdy_m, err_m;

    assign ifa.Pselx = tgt ? 3'b000 : psel;
    assign ifb.Pselx = tgt ? psel : 3'b000;
    assign ifa.Penable = pen;
    assign ifb.Penable = pen;
    assign ifa.Pwrite = wr;
    assign ifb.Pwrite = wr;
    assign ifa.Paddr = addr;
    assign ifb.Paddr = addr;
    assign ifa.Pwdata = wdata;
    assign ifb.Pwdata = wdata;
    assign rd_m = tgt ? ifb.Prdata : ifa.Prdata;
    assign rdy_m = tgt ? ifb.Pready : ifa.Pready;
    assign err_m = tgt ? ifb.Pslverr : ifa.Pslverr;

    apb_slave_regfile #(.SLV_ID(0), .WAIT_STATES(0)) dut_a (.Hclk(Hclk), .Hreset(Hreset), .apb(ifa.slave));
    apb_slave_regfile #(.SLV_ID(0), .WAIT_STATES(2)) dut_b (.Hclk(Hclk), .Hreset(Hreset), .apb(ifb.slave));

    int checks = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Ends in the sampled access cycle with the bus still driven, so a following call is back-to-back
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] ps,
                        output logic [31:0] rd, output logic rdy, output logic er, output int nw);
        @(negedge Hclk);
        psel = ps; pen = 1'b0; wr = w; addr = a; wdata = d;
        @(negedge Hclk);
        pen = 1'b1;
        nw = 0;
        @(negedge Hclk);
        while (!rdy_m && nw < 8) begin
            nw++;
            @(negedge Hclk);
        end
        rd = rd_m; rdy = rdy_m; er = err_m;
    endtask

    task automatic bus_idle();
        @(negedge Hclk);
        psel = 3'b000; pen = 1'b0;
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  ps;
        logic [31:0] rd;
        logic        rdy;
        logic        err;
    } vec_t;

    vec_t vt [15];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        rdy, er;
        int          nw;
        vt[0]  = '{1'b1, 32'h8000_0008, 32'hDEAD_BEEF, 3'b001, 32'h0,         1'b1, 1'b0};
        vt[1]  = '{1'b0, 32'h8000_0008, 32'h0,         3'b001, 32'hDEAD_BEEF, 1'b1, 1'b0};
        vt[2]  = '{1'b0, 32'h8000_0004, 32'h0,         3'b001, 32'h0,         1'b1, 1'b0};
        vt[3]  = '{1'b0, 32'h8000_000C, 32'h0,         3'b001, 32'h0,         1'b1, 1'b0};
        vt[4]  = '{1'b1, 32'h8000_0040, 32'h1111_1111, 3'b001, 32'h0,         1'b1, 1'b1};
        vt[5]  = '{1'b0, 32'h8000_0040, 32'h0,         3'b001, 32'h0,         1'b1, 1'b1};
        vt[6]  = '{1'b1, 32'h8000_0002, 32'h2222_2222, 3'b001, 32'h0,         1'b1, 1'b1};
        vt[7]  = '{1'b0, 32'h8000_0002, 32'h0,         3'b001, 32'h0,         1'b1, 1'b1};
        vt[8]  = '{1'b0, 32'h8000_0000, 32'h0,         3'b001, 32'h0,         1'b1, 1'b0};
        vt[9]  = '{1'b1, 32'h9000_0000, 32'h3333_3333, 3'b001, 32'h0,         1'b1, 1'b1};
        vt[10] = '{1'b1, 32'h8000_003C, 32'hCAFE_F00D, 3'b001, 32'h0,         1'b1, 1'b0};
        vt[11] = '{1'b0, 32'h8000_003C, 32'h0,         3'b001, 32'hCAFE_F00D, 1'b1, 1'b0};
        vt[12] = '{1'b1, 32'h8000_0000, 32'h4444_4444, 3'b010, 32'h0,         1'b0, 1'b0};
        vt[13] = '{1'b0, 32'h8000_0000, 32'h0,         3'b011, 32'h0,         1'b1, 1'b0};
        vt[14] = '{1'b0, 32'h8000_0008, 32'h0,         3'b111, 32'hDEAD_BEEF, 1'b1, 1'b0};
        tgt = 1'b0; psel = 3'b000; pen = 1'b0; wr = 1'b0; addr = 32'h0; wdata = 32'h0;
        repeat (2) @(negedge Hclk);
        chk("reset_prdata", ifa.Prdata, 32'h0);
        chk("reset_pready", {31'h0, ifa.Pready}, 32'h0);
        chk("reset_pslverr", {31'h0, ifa.Pslverr}, 32'h0);
        chk("reset_pready_b", {31'h0, ifb.Pready}, 32'h0);
        Hreset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            xfer(1'b0, 32'h8000_0000 + 32'(i * 4), 32'h0, 3'b001, rd, rdy, er, nw);
            chk($sformatf("init_rd%0d", i), rd, 32'h0);
            chk($sformatf("init_rdy%0d", i), {31'h0, rdy}, 32'h1);
            chk($sformatf("init_err%0d", i), {31'h0, er}, 32'h0);
        end
        for (int i = 0; i < 15; i++) begin
            xfer(vt[i].w, vt[i].a, vt[i].d, vt[i].ps, rd, rdy, er, nw);
            chk($sformatf("vec%0d_rdy", i), {31'h0, rdy}, {31'h0, vt[i].rdy});
            if (vt[i].rdy) chk($sformatf("vec%0d_err", i), {31'h0, er}, {31'h0, vt[i].err});
            if (!vt[i].w) chk($sformatf("vec%0d_rd", i), rd, vt[i].rd);
        end
        bus_idle();
        tgt = 1'b1;
        xfer(1'b1, 32'h8000_0004, 32'h1234_5678, 3'b001, rd, rdy, er, nw);
        chk("ws_write_waits", 32'(nw), 32'd2);
        chk("ws_write_rdy", {31'h0, rdy}, 32'h1);
        chk("ws_write_err", {31'h0, er}, 32'h0);
        xfer(1'b0, 32'h8000_0004, 32'h0, 3'b001, rd, rdy, er, nw);
        chk("ws_read_waits", 32'(nw), 32'd2);
        chk("ws_read_data", rd, 32'h1234_5678);
        bus_idle();
        @(negedge Hclk);
        psel = 3'b001; pen = 1'b0; wr = 1'b1; addr = 32'h8000_0004; wdata = 32'hAAAA_0000;
        @(negedge Hclk);
        pen = 1'b1;
        @(negedge Hclk);
        chk("abort_wait_pready", {31'h0, ifb.Pready}, 32'h0);
        psel = 3'b000; pen = 1'b0;
        @(negedge Hclk);
        chk("abort_idle_pready", {31'h0, ifb.Pready}, 32'h0);
        chk("abort_idle_pslverr", {31'h0, ifb.Pslverr}, 32'h0);
        xfer(1'b0, 32'h8000_0004, 32'h0, 3'b001, rd, rdy, er, nw);
        chk("abort_keeps_value", rd, 32'h1234_5678);
        bus_idle();
        @(negedge Hclk);
        psel = 3'b001; pen = 1'b0; wr = 1'b1; addr = 32'h8000_0004; wdata = 32'h5555_5555;
        @(negedge Hclk);
        pen = 1'b1;
        repeat (3) @(negedge Hclk);
        chk("rst_pre_pready", {31'h0, ifb.Pready}, 32'h1);
        Hreset = 1'b1;
        #1;
        chk("rst_async_prdata_b", ifb.Prdata, 32'h0);
        chk("rst_async_pready_b", {31'h0, ifb.Pready}, 32'h0);
        chk("rst_async_pslverr_b", {31'h0, ifb.Pslverr}, 32'h0);
        chk("rst_async_prdata_a", ifa.Prdata, 32'h0);
        bus_idle();
        @(negedge Hclk);
        Hreset = 1'b0;
        xfer(1'b0, 32'h8000_0004, 32'h0, 3'b001, rd, rdy, er, nw);
        chk("post_rst_read", rd, 32'h0);
        chk("post_rst_rdy", {31'h0, rdy}, 32'h1);
        bus_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- APB responder at the far end of the AHB-to-APB bridge: a parameterised 32-bit register file answering the bridge's APB initiator.
- Decodes its own Pselx bit and runs a setup/access state machine with optional programmable wait states.
- Returns Prdata with Pready and Pslverr.
- One instance per Pselx bit; it also serves as the bench memory model for closing the bridge loop in simulation and formal.

Parameters:
- SLV_ID, 0, index of the Pselx bit this instance responds to (0..2).
- BASE_ADDR, 32'h8000_0000, region base; only bits [31:10] are compared, so each region is 1 KB.
- DEPTH, 16, number of 32-bit registers (1..256).
- WAIT_STATES, 0, access-phase cycles with Pready low before completion. Must be 0 when paired with the current bridge, which does not sample Pready.

Ports:
- Hclk  input  1  single clock; all state changes on the rising edge.
- Hreset  input  1  asynchronous active-high reset.
- Pselx  input  3  one-hot slave select from the bridge.
- Penable  input  1  APB access-phase strobe.
- Pwrite  input  1  1 = write, 0 = read.
- Paddr  input  32  byte address.
- Pwdata  input  32  write data.
- Prdata  output  32  read data.
- Pready  output  1  transfer completion.
- Pslverr  output  1  error response; valid only while Pready=1.

Behaviour:
- Reset:
  - Clock is Hclk; reset is asynchronous, active-high, on port Hreset.
  - On reset: all registers = 0, Prdata = 0, Pready = 0, Pslverr = 0, FSM = S_IDLE, wait counter = 0.
  - Reset asserted mid-transfer aborts the transfer with no write commit.
- Definitions:
  - sel = Pselx[SLV_ID].
  - idx = Paddr[9:2].
  - err = (Paddr[31:10] != BASE_ADDR[31:10]) | (Paddr[1:0] != 0) | (idx >= DEPTH).
- FSM states and transitions:
  - S_IDLE: sel & ~Penable -> S_SETUP. Otherwise stay. Penable high without a prior setup is ignored.
  - S_SETUP: at the clock edge that enters S_SETUP, latch write, err and idx into internal registers. For a read, load Prdata <= err ? 0 : reg[idx]. Clear the wait counter.
  - S_SETUP, next cycle: sel & Penable -> S_ACCESS. sel & ~Penable -> S_SETUP (restart, relatch). ~sel -> S_IDLE (abort).
  - S_ACCESS: Pready is combinational = (wait_cnt == WAIT_STATES). While Pready = 0, wait_cnt increments by 1 per cycle (saturating at WAIT_STATES).
  - S_ACCESS completion: when Pready = 1 and sel & Penable, the transfer completes; next state is S_IDLE.
  - S_ACCESS abort: sel or Penable dropping before completion -> S_IDLE, no write commit.
- Write commit:
  - Occurs only on the completing cycle: reg[latched idx] <= Pwdata, when write and ~err.
  - Erroring writes leave all registers unchanged.
- Responses:
  - Pslverr = latched err & Pready & (state == S_ACCESS); 0 otherwise.
  - Prdata holds its value until the next read setup. Erroring reads return 32'h0.
- Latency:
  - With WAIT_STATES = 0, Pready is high in the first access cycle.
  - Read data is valid in that same cycle; a setup at edge T gives data at T+1. This matches the bridge's fixed two-cycle setup/enable sequence.
- Back-to-back:
  - A new setup (sel & ~Penable) in the cycle after completion is accepted from S_IDLE with no bubble beyond the APB idle.
- Pready outside S_ACCESS is 0.
- Pselx bits other than SLV_ID are ignored. Multiple bits set is legal; this instance reacts only to its own bit.

Test Plan:
- Reset, then read idx 0..DEPTH-1 -> every Prdata = 32'h0, Pready = 1 in the access cycle, Pslverr = 0.
- Write 32'hDEAD_BEEF to 32'h8000_0008, then read 32'h8000_0008 -> Prdata = 32'hDEAD_BEEF one cycle after the read setup; reg 1 and reg 3 unchanged.
- Access 32'h8000_0040 (idx 16 with DEPTH = 16), and separately 32'h8000_0002 -> Pslverr = 1 with Pready. Prdata = 0 on read. A subsequent read of reg 0 shows no corruption.
- WAIT_STATES = 2, write 32'h1234_5678 to 32'h8000_0004 -> Pready low for 2 access cycles and high on the 3rd; the commit is visible only after that edge.
- Drop Pselx[SLV_ID] during a write access with WAIT_STATES = 2 -> FSM returns to S_IDLE and the register keeps its old value. Repeat with Hreset asserted mid-access -> all outputs 0 immediately, without waiting for a clock edge.
- Back-to-back write then read to the same address with WAIT_STATES = 0 -> the read returns the newly written data; the Pselx bit for a different SLV_ID produces no response.
